oam_dma_controller: RTL

- Game Boy OAM DMA engine and memory-bus arbiter between the CPU port and the memory map's CPU-side port.
- Owns register FF46. A CPU write to FF46 copies 160 bytes from {src_hi,00h}..{src_hi,9Fh} to FE00h..FE9Fh.
- While a copy runs, the block owns the memory bus and masks CPU accesses.
- Clocked on the CPU clock domain.

---
 rtl/oam_dma_controller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/oam_dma_controller.sv
// Game Boy OAM DMA engine (FF46) and CPU/memory bus arbiter.
// Optional macro HRAM_PASSTHRU_EN lets CPU HRAM accesses (FF80h-FFFEh) pre-empt the DMA for one cycle each.
module oam_dma_controller #(
    parameter int RD_LAT  = 1,
    parameter int DMA_LEN = 160
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wren,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] mem_addr,
    output logic        mem_wren,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        dma_active,
    output logic        dma_done
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_RD, S_WAIT, S_WR} state_t;

    state_t      r_state;
    logic [7:0]  r_src_hi;
    logic [7:0]  r_index;
    logic [1:0]  r_wait_cnt;
    logic        r_dma_active;
    logic        r_dma_done;
    logic [7:0]  r_hold;
    logic        r_hold_valid;
    logic        r_pipe_mem [RD_LAT];
    logic [7:0]  r_pipe_val [RD_LAT];

    logic        w_ff46_hit;
    logic        w_ff46_wr;
    logic        w_hram_grab;
    logic        w_last;
    logic [7:0]  w_eff_src;
    logic        w_sel_mem;
    logic [7:0]  w_sel_val;

    assign w_ff46_hit = (cpu_addr == 16'hFF46);
    assign w_ff46_wr  = w_ff46_hit && cpu_wren;
    assign w_last     = (r_index == 8'(DMA_LEN - 1));
    // Sources in E0h-FFh page range fold back onto C0h-DFh (echo RAM).
    assign w_eff_src  = (r_src_hi >= 8'hE0) ? (r_src_hi - 8'h20) : r_src_hi;

`ifdef HRAM_PASSTHRU_EN
    assign w_hram_grab = r_dma_active && (cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE);
`else
    assign w_hram_grab = 1'b0;
`endif

    always_comb begin
        mem_addr  = cpu_addr;
        mem_wren  = 1'b0;
        mem_wdata = cpu_wdata;
        if (w_hram_grab) begin
            mem_wren = cpu_wren;
        end else begin
            case (r_state)
                S_IDLE:       mem_wren = cpu_wren && !w_ff46_hit;
                S_RD, S_WAIT: mem_addr = {w_eff_src, r_index};
                S_WR: begin
                    mem_addr  = 16'hFE00 + {8'h00, r_index};
                    mem_wren  = 1'b1;
                    mem_wdata = r_hold_valid ? r_hold : mem_rdata;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_src_hi     <= 8'h00;
            r_index      <= 8'h00;
            r_wait_cnt   <= 2'd0;
            r_dma_active <= 1'b0;
            r_dma_done   <= 1'b0;
            r_hold       <= 8'h00;
            r_hold_valid <= 1'b0;
        end else begin
            r_dma_done <= 1'b0;
            if (w_ff46_wr) begin
                r_src_hi     <= cpu_wdata;
                r_state      <= S_START;
                r_dma_active <= 1'b1;
                r_index      <= 8'h00;
                r_hold_valid <= 1'b0;
            end else if (w_hram_grab) begin
                // A stalled WR keeps the byte already on mem_rdata; a stalled WAIT reissues its read.
                if (r_state == S_WR && !r_hold_valid) begin
                    r_hold       <= mem_rdata;
                    r_hold_valid <= 1'b1;
                end
                if (r_state == S_WAIT) r_state <= S_RD;
            end else begin
                case (r_state)
                    S_START: begin
                        r_index <= 8'h00;
                        r_state <= S_RD;
                    end
                    S_RD: begin
                        r_wait_cnt <= 2'd0;
                        r_state    <= (RD_LAT > 1) ? S_WAIT : S_WR;
                    end
                    S_WAIT: begin
                        r_wait_cnt <= r_wait_cnt + 2'd1;
                        if (r_wait_cnt == 2'(RD_LAT - 2)) r_state <= S_WR;
                    end
                    S_WR: begin
                        r_hold_valid <= 1'b0;
                        if (w_last) begin
                            r_state      <= S_IDLE;
                            r_dma_active <= 1'b0;
                            r_dma_done   <= 1'b1;
                        end else begin
                            r_index <= r_index + 8'd1;
                            r_state <= S_RD;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read-source select travels alongside the memory latency so cpu_rdata lines up with mem_rdata.
    assign w_sel_mem = !w_ff46_hit && (!r_dma_active || w_hram_grab);
    assign w_sel_val = w_ff46_hit ? r_src_hi : 8'hFF;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe_mem[i] <= 1'b0;
                r_pipe_val[i] <= 8'h00;
            end
        end else begin
            r_pipe_mem[0] <= w_sel_mem;
            r_pipe_val[0] <= w_sel_val;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_mem[i] <= r_pipe_mem[i-1];
                r_pipe_val[i] <= r_pipe_val[i-1];
            end
        end
    end

    assign cpu_rdata  = r_pipe_mem[RD_LAT-1] ? mem_rdata : r_pipe_val[RD_LAT-1];
    assign dma_active = r_dma_active;
    assign dma_done   = r_dma_done;

endmodule
